// File: rtl/sd_block_responder_if.sv
// SD block-access handshake between initiator and responder.
// Initiator drives request and write data; responder drives ack and buffer bus.
interface sd_block_responder_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/sd_block_responder.sv
// Ramdisk responder for the SD block handshake, image loaded over a byte port.
// SD_BLOCK_RESPONDER_WRITE_EN enables block writes into the image RAM.
module sd_block_responder #(
  parameter int IMG_BLOCKS = 64,
  parameter int ACK_DELAY  = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  sd_block_responder_if.slave sd,
  input  logic                ld_wr,
  input  logic [23:0]         ld_addr,
  input  logic [7:0]          ld_data,
  input  logic                ld_done,
  output logic                img_mounted,
  output logic [63:0]         img_size,
  output logic                img_readonly,
  output logic                err
);
  localparam int IMG_BYTES = IMG_BLOCKS * 512;
  localparam int AW = $clog2(IMG_BYTES);
  localparam int BW = AW - 9;
  localparam logic [31:0] IMG_BYTES_L = 32'(IMG_BYTES);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_XFER, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [BW-1:0] lba_q, lba_d;
  logic          rd_dir_q, rd_dir_d;
  logic          ok_q, ok_d;
  logic          ack_q, ack_d;
  logic          bwr_q, bwr_d;
  logic [8:0]    baddr_q, baddr_d;
  logic [7:0]    bdout_q, bdout_d;
  logic          pulse_q, pulse_d;
  logic          mounted_q, mounted_d;
  logic          loading_q, loading_d;
  logic [63:0]   size_q, size_d;
  logic          err_q, err_d;

  logic [7:0]    mem [IMG_BYTES];
  logic [7:0]    ram_q;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [7:0]    wdata;

  logic          ld_ok;
  logic          req;
  logic          in_range;
  logic [63:0]   ld_end;

  assign ld_ok = ld_wr && (state_q == S_IDLE)
              && ({8'b0, ld_addr} < IMG_BYTES_L);
  assign ld_end = {40'b0, ld_addr} + 64'd1;
  assign req = sd.sd_rd | sd.sd_wr;
  assign in_range = mounted_q
    && ({32'b0, sd.sd_lba} < ((size_q + 64'd511) >> 9));
  assign raddr = {lba_q, cnt_q[8:0]};

  // Next-state and output decode for the handshake FSM and the loader.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lba_d     = lba_q;
    rd_dir_d  = rd_dir_q;
    ok_d      = ok_q;
    ack_d     = ack_q;
    bwr_d     = 1'b0;
    baddr_d   = baddr_q;
    bdout_d   = bdout_q;
    pulse_d   = 1'b0;
    mounted_d = mounted_q;
    loading_d = loading_q;
    size_d    = size_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (ld_ok) begin
          loading_d = 1'b1;
          if (!loading_q) begin
            mounted_d = 1'b0;
            size_d    = ld_end;
          end else if (ld_end > size_q) begin
            size_d = ld_end;
          end
        end else if (req && !loading_q) begin
          state_d  = S_WAIT;
          cnt_d    = 10'd1;
          lba_d    = sd.sd_lba[BW-1:0];
          rd_dir_d = sd.sd_rd;
          ok_d     = in_range;
          err_d    = !in_range;
        end
      end
      S_WAIT: begin
        if (cnt_q == 10'(ACK_DELAY)) begin
          state_d = S_XFER;
          ack_d   = 1'b1;
          cnt_d   = 10'd0;
          baddr_d = 9'd0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_XFER: begin
        cnt_d = cnt_q + 10'd1;
        if (rd_dir_q) begin
          if (cnt_q >= 10'd1 && cnt_q <= 10'd512) begin
            bwr_d   = 1'b1;
            baddr_d = 9'(cnt_q - 10'd1);
            bdout_d = ok_q ? ram_q : 8'h00;
          end
          if (cnt_q == 10'd513) begin
            ack_d   = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          if (cnt_q < 10'd511) begin
            baddr_d = 9'(cnt_q + 10'd1);
          end
          if (cnt_q == 10'd512) begin
            ack_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (ld_done) begin
      loading_d = 1'b0;
      mounted_d = 1'b1;
      pulse_d   = 1'b1;
    end
  end

  // RAM write port: loader in IDLE, block writes during a write transfer.
  always_comb begin
    we    = ld_ok;
    waddr = ld_addr[AW-1:0];
    wdata = ld_data;
`ifdef SD_BLOCK_RESPONDER_WRITE_EN
    if (state_q == S_XFER && !rd_dir_q && ok_q
        && cnt_q >= 10'd1 && cnt_q <= 10'd512) begin
      we    = 1'b1;
      waddr = {lba_q, 9'(cnt_q - 10'd1)};
      wdata = sd.sd_buff_din;
    end
`endif
  end

  // Image RAM with one-cycle registered read; contents survive reset.
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[raddr];
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lba_q     <= '0;
      rd_dir_q  <= 1'b0;
      ok_q      <= 1'b0;
      ack_q     <= 1'b0;
      bwr_q     <= 1'b0;
      baddr_q   <= '0;
      bdout_q   <= '0;
      pulse_q   <= 1'b0;
      mounted_q <= 1'b0;
      loading_q <= 1'b0;
      size_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lba_q     <= lba_d;
      rd_dir_q  <= rd_dir_d;
      ok_q      <= ok_d;
      ack_q     <= ack_d;
      bwr_q     <= bwr_d;
      baddr_q   <= baddr_d;
      bdout_q   <= bdout_d;
      pulse_q   <= pulse_d;
      mounted_q <= mounted_d;
      loading_q <= loading_d;
      size_q    <= size_d;
      err_q     <= err_d;
    end
  end

  assign sd.sd_ack       = ack_q;
  assign sd.sd_buff_wr   = bwr_q;
  assign sd.sd_buff_addr = baddr_q;
  assign sd.sd_buff_dout = bdout_q;
  assign img_mounted     = pulse_q;
  assign img_size        = size_q;
  assign err             = err_q;
`ifdef SD_BLOCK_RESPONDER_WRITE_EN
  assign img_readonly = 1'b0;
`else
  assign img_readonly = 1'b1;
`endif
endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: load, read, write, range, reset.
// Plays the SD initiator and its registered-address write buffer.
module tb_sd_block_responder;
  localparam int ACK_DELAY = 4;

  logic        clk;
  logic        reset_n;
  logic        ld_wr;
  logic [23:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_done;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [1024];
  logic [7:0] rdata [512];

  sd_block_responder_if sdi ();

  sd_block_responder #(
    .IMG_BLOCKS(64),
    .ACK_DELAY (ACK_DELAY)
  ) dut (
    .clk_sys     (clk),
    .reset_n     (reset_n),
    .sd          (sdi.slave),
    .ld_wr       (ld_wr),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .img_readonly(img_readonly),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bad_bytes(input int base, input bit zero);
    int n = 0;
    for (int k = 0; k < 512; k++) begin
      if (zero) begin
        if (rdata[k] !== 8'h00) n++;
      end else if (rdata[k] !== model[base + k]) n++;
    end
    return n;
  endfunction

  task automatic xfer(input logic rd, input logic wr,
                      input logic [31:0] lba,
                      output int rise, output int fall,
                      output int nstrobe, output int poserr,
                      output logic err_a);
    logic [8:0] prev_addr;
    bit done;
    int m;
    rise = -1; fall = -1; nstrobe = 0; poserr = 0;
    err_a = 1'bx; prev_addr = '0; done = 0;
    for (int k = 0; k < 512; k++) rdata[k] = 8'hxx;
    @(negedge clk);
    sdi.sd_rd = rd; sdi.sd_wr = wr; sdi.sd_lba = lba;
    sdi.sd_buff_din = 8'h00;
    for (int j = 0; j < 1200 && !done; j++) begin
      @(negedge clk);
      if (rise < 0 && sdi.sd_ack) begin
        rise = j; err_a = err;
        sdi.sd_rd = 1'b0; sdi.sd_wr = 1'b0;
      end
      if (rise >= 0) begin
        m = j - rise;
        if (sdi.sd_buff_wr) begin
          nstrobe++;
          if (!(m >= 2 && int'(sdi.sd_buff_addr) == m - 2)) poserr++;
          rdata[sdi.sd_buff_addr] = sdi.sd_buff_dout;
        end
        if (wr) begin
          if (!rd && sdi.sd_ack && m <= 511
              && int'(sdi.sd_buff_addr) != m) poserr++;
          sdi.sd_buff_din = 8'hA5 ^ prev_addr[7:0];
          prev_addr = sdi.sd_buff_addr;
        end
        if (!sdi.sd_ack) begin fall = m; done = 1; end
      end
    end
    sdi.sd_rd = 1'b0; sdi.sd_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic ro_exp;
`ifdef SD_BLOCK_RESPONDER_WRITE_EN
    ro_exp = 1'b0;
`else
    ro_exp = 1'b1;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({sdi.sd_ack, sdi.sd_buff_wr, img_mounted, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
        {sdi.sd_ack, sdi.sd_buff_wr, img_mounted, err});
    end
    checks++;
    if ({sdi.sd_buff_addr, sdi.sd_buff_dout} !== 17'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr %0d dout %0h expected 0 0",
        sdi.sd_buff_addr, sdi.sd_buff_dout);
    end
    checks++;
    if (img_size !== 64'd0) begin
      errors++;
      $display("FAIL reset_size: got %0d expected 0", img_size);
    end
    checks++;
    if (img_readonly !== ro_exp) begin
      errors++;
      $display("FAIL readonly: got %b expected %b", img_readonly, ro_exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load();
    int pulses;
    logic first;
    for (int a = 0; a < 1024; a++) begin
      @(negedge clk);
      ld_wr = 1'b1; ld_addr = 24'(a); ld_data = 8'(a);
      model[a] = 8'(a);
    end
    @(negedge clk);
    ld_wr = 1'b0; ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    first = img_mounted;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (img_mounted) pulses++;
      @(negedge clk);
    end
    checks++;
    if (first !== 1'b1) begin
      errors++;
      $display("FAIL mount_timing: got %b expected 1", first);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL mount_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (img_size !== 64'd1024) begin
      errors++;
      $display("FAIL img_size: got %0d expected 1024", img_size);
    end
  endtask

  task automatic test_read();
    int rise, fall, ns, pe, bad;
    logic ea;
    xfer(1'b1, 1'b0, 32'd1, rise, fall, ns, pe, ea);
    checks++;
    if (rise != ACK_DELAY) begin
      errors++;
      $display("FAIL rd_ack_rise: got %0d expected %0d", rise, ACK_DELAY);
    end
    checks++;
    if (fall != 514) begin
      errors++;
      $display("FAIL rd_ack_fall: got %0d expected 514", fall);
    end
    checks++;
    if (ns != 512 || pe != 0) begin
      errors++;
      $display("FAIL rd_strobes: got %0d (%0d misplaced) expected 512 (0)",
        ns, pe);
    end
    bad = bad_bytes(512, 1'b0);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rd_data: got %0d bad bytes expected 0", bad);
    end
    checks++;
    if (ea !== 1'b0) begin
      errors++;
      $display("FAIL rd_err: got %b expected 0", ea);
    end
  endtask

  task automatic test_write();
    int rise, fall, ns, pe, bad;
    logic ea;
    xfer(1'b0, 1'b1, 32'd0, rise, fall, ns, pe, ea);
`ifdef SD_BLOCK_RESPONDER_WRITE_EN
    for (int k = 0; k < 512; k++) model[k] = 8'hA5 ^ 8'(k);
`endif
    checks++;
    if (rise != ACK_DELAY || fall != 513) begin
      errors++;
      $display("FAIL wr_timing: got rise %0d fall %0d expected %0d 513",
        rise, fall, ACK_DELAY);
    end
    checks++;
    if (ns != 0 || pe != 0) begin
      errors++;
      $display("FAIL wr_bus: got %0d strobes %0d addr errs expected 0 0",
        ns, pe);
    end
    checks++;
    if (ea !== 1'b0) begin
      errors++;
      $display("FAIL wr_err: got %b expected 0", ea);
    end
    xfer(1'b1, 1'b0, 32'd0, rise, fall, ns, pe, ea);
    bad = bad_bytes(0, 1'b0);
    checks++;
    if (bad != 0 || ns != 512) begin
      errors++;
      $display("FAIL wr_readback: got %0d bad %0d strobes expected 0 512",
        bad, ns);
    end
  endtask

  task automatic test_out_of_range();
    int rise, fall, ns, pe, bad;
    logic ea;
    logic [31:0] lbas [2];
    lbas[0] = 32'd2;
    lbas[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      xfer(1'b1, 1'b0, lbas[i], rise, fall, ns, pe, ea);
      bad = bad_bytes(0, 1'b1);
      checks++;
      if (rise != ACK_DELAY || fall != 514 || ns != 512) begin
        errors++;
        $display("FAIL oor_hs lba %h: got rise %0d fall %0d n %0d",
          lbas[i], rise, fall, ns);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL oor_zero lba %h: got %0d nonzero expected 0",
          lbas[i], bad);
      end
      checks++;
      if (ea !== 1'b1 || err !== 1'b1) begin
        errors++;
        $display("FAIL oor_err lba %h: got %b/%b expected 1",
          lbas[i], ea, err);
      end
    end
    xfer(1'b1, 1'b0, 32'd1, rise, fall, ns, pe, ea);
    bad = bad_bytes(512, 1'b0);
    checks++;
    if (ea !== 1'b0 || bad != 0) begin
      errors++;
      $display("FAIL err_clear: got err %b bad %0d expected 0 0", ea, bad);
    end
  endtask

  task automatic test_rd_wr_both();
    int rise, fall, ns, pe, bad;
    logic ea;
    xfer(1'b1, 1'b1, 32'd0, rise, fall, ns, pe, ea);
    bad = bad_bytes(0, 1'b0);
    checks++;
    if (ns != 512 || fall != 514 || bad != 0) begin
      errors++;
      $display("FAIL both_as_read: got n %0d fall %0d bad %0d",
        ns, fall, bad);
    end
    xfer(1'b1, 1'b0, 32'd0, rise, fall, ns, pe, ea);
    bad = bad_bytes(0, 1'b0);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL both_ram: got %0d changed bytes expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int rise, fall, ns, pe;
    logic ea;
    bit hit = 0;
    @(negedge clk);
    sdi.sd_rd = 1'b1; sdi.sd_lba = 32'd0;
    for (int i = 0; i < 1200 && !hit; i++) begin
      @(negedge clk);
      if (sdi.sd_ack) sdi.sd_rd = 1'b0;
      if (sdi.sd_buff_wr && sdi.sd_buff_addr == 9'd100) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach: got no byte 100 expected byte 100");
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sdi.sd_ack !== 1'b0 || sdi.sd_buff_wr !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got ack %b wr %b expected 0 0",
        sdi.sd_ack, sdi.sd_buff_wr);
    end
    sdi.sd_rd = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (img_size !== 64'd0) begin
      errors++;
      $display("FAIL mid_size: got %0d expected 0", img_size);
    end
    xfer(1'b1, 1'b0, 32'd0, rise, fall, ns, pe, ea);
    checks++;
    if (rise != ACK_DELAY || fall != 514 || ns != 512 || pe != 0) begin
      errors++;
      $display("FAIL mid_after: got rise %0d fall %0d n %0d pe %0d",
        rise, fall, ns, pe);
    end
    checks++;
    if (ea !== 1'b1) begin
      errors++;
      $display("FAIL mid_err: got %b expected 1", ea);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ld_wr = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    sdi.sd_rd = 1'b0; sdi.sd_wr = 1'b0;
    sdi.sd_lba = '0; sdi.sd_buff_din = '0;
    test_reset();
    test_load();
    test_read();
    test_write();
    test_out_of_range();
    test_rd_wr_both();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
